alu: RTL and testbench

Single-cycle-registered 8-bit arithmetic/logic unit. It takes two unsigned byte operands and a 4-bit operation select, and produces an 8-bit result plus a carry/flag bit. Both outputs are registered on the rising clock edge. It is the datapath execute block: the control logic drives `sel`, and `result`/`carry` feed the register-file write-back.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_comb.sv | 69 ++++++
 rtl/alu.sv | 41 ++++
 tb/tb_alu.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and operand width for the 8-bit execute-stage ALU.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } opcode_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational opcode decode and datapath for the ALU.
// The divider is built only when ALU_DIV_EN is defined; otherwise DIV yields 0/0.
module alu_comb
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  logic [3:0]       i_sel,
    output logic [ALU_W-1:0] o_result,
    output logic             o_carry
);

    logic [ALU_W:0]     w_sum;
    logic [ALU_W:0]     w_diff;
    logic [2*ALU_W-1:0] w_prod;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // The ninth bit of the wrapped difference is the borrow.
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod = i_a * i_b;

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (opcode_e'(i_sel))
            OP_ADD:  {o_carry, o_result} = w_sum;
            OP_SUB:  {o_carry, o_result} = w_diff;
            OP_MUL: begin
                o_result = w_prod[ALU_W-1:0];
                o_carry  = |w_prod[2*ALU_W-1:ALU_W];
            end
            OP_DIV: begin
`ifdef ALU_DIV_EN
                if (i_b == '0) begin
                    o_result = '1;
                    o_carry  = 1'b1;
                end else begin
                    o_result = i_a / i_b;
                end
`else
                o_result = '0;
`endif
            end
            OP_SHL: begin
                o_result = {i_a[ALU_W-2:0], 1'b0};
                o_carry  = i_a[ALU_W-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[ALU_W-1:1]};
                o_carry  = i_a[0];
            end
            OP_ROL:  o_result = {i_a[ALU_W-2:0], i_a[ALU_W-1]};
            OP_ROR:  o_result = {i_a[0], i_a[ALU_W-1:1]};
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_NAND: o_result = ~(i_a & i_b);
            OP_XNOR: o_result = ~(i_a ^ i_b);
            OP_GT:   o_result = {{(ALU_W-1){1'b0}}, (i_a > i_b)};
            OP_EQ:   o_result = {{(ALU_W-1){1'b0}}, (i_a == i_b)};
            default: begin
                o_result = '0;
                o_carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit ALU with one registered stage; result/carry feed register-file write-back.
// Optional divider is enabled by defining ALU_DIV_EN.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [3:0]       sel,
    output logic [ALU_W-1:0] result,
    output logic             carry
);

    logic [ALU_W-1:0] w_result;
    logic             w_carry;
    logic [ALU_W-1:0] r_result;
    logic             r_carry;

    alu_comb u_comb (
        .i_a      (A),
        .i_b      (B),
        .i_sel    (sel),
        .o_result (w_result),
        .o_carry  (w_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_carry  <= 1'b0;
        end else begin
            r_result <= w_result;
            r_carry  <= w_carry;
        end
    end

    assign result = r_result;
    assign carry  = r_carry;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed expectations,
// the monitor pops one per issued cycle and compares after the capturing edge.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] sel;
    logic [7:0] result;
    logic       carry;

    typedef struct {
        logic [7:0] r;
        logic       c;
        string      name;
    } exp_t;

    exp_t q[$];
    bit   pending;
    int   checks;
    int   errors;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .sel    (sel),
        .result (result),
        .carry  (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic r_v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s, input logic [7:0] er, input logic ec,
                         input string nm);
        exp_t e;
        @(negedge clk);
        rst = r_v;
        A   = a;
        B   = b;
        sel = s;
        e.r = er;
        e.c = ec;
        e.name = nm;
        q.push_back(e);
        pending = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        pending = 1'b0;
    endtask

    // Monitor: one expectation per cycle in which stimulus was presented.
    always @(posedge clk) begin
        bit   p;
        exp_t e;
        p = pending;
        #1;
        if (p) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: result=%02h carry=%0d with nothing expected", result, carry);
            end else begin
                e = q.pop_front();
                if (result !== e.r || carry !== e.c) begin
                    errors++;
                    $display("FAIL %s: got result=%02h carry=%0d, want result=%02h carry=%0d",
                             e.name, result, carry, e.r, e.c);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; A = 8'h00; B = 8'h00; sel = 4'h0;
        pending = 1'b0; checks = 0; errors = 0;

        // Reset holds outputs at zero regardless of operands
        issue(1, 8'hFF, 8'hFF, 4'h0, 8'h00, 0, "rst_cyc0");
        issue(1, 8'hFF, 8'hFF, 4'h0, 8'h00, 0, "rst_cyc1");
        issue(0, 8'hFF, 8'hFF, 4'h0, 8'hFE, 1, "rst_release_add");

        issue(0, 8'h35, 8'hE1, 4'h0, 8'h16, 1, "add_35_e1");
        issue(0, 8'h35, 8'hE1, 4'h1, 8'h54, 1, "sub_35_e1");
        issue(0, 8'h35, 8'hE1, 4'h2, 8'h95, 1, "mul_35_e1");
        issue(0, 8'h35, 8'hE1, 4'h8, 8'h21, 0, "and_35_e1");
        issue(0, 8'h35, 8'hE1, 4'h9, 8'hF5, 0, "or_35_e1");
        issue(0, 8'h35, 8'hE1, 4'hA, 8'hD4, 0, "xor_35_e1");
        issue(0, 8'h35, 8'hE1, 4'hB, 8'h0A, 0, "nor_35_e1");
        issue(0, 8'h35, 8'hE1, 4'hC, 8'hDE, 0, "nand_35_e1");
        issue(0, 8'h35, 8'hE1, 4'hD, 8'h2B, 0, "xnor_35_e1");

        issue(0, 8'h71, 8'hAD, 4'h0, 8'h1E, 1, "add_71_ad");
        issue(0, 8'h71, 8'hAD, 4'h4, 8'hE2, 0, "shl_71");
        issue(0, 8'h71, 8'hAD, 4'h5, 8'h38, 1, "shr_71");
        issue(0, 8'h71, 8'hAD, 4'h6, 8'hE2, 0, "rol_71");
        issue(0, 8'h71, 8'hAD, 4'h7, 8'hB8, 0, "ror_71");
        issue(0, 8'h71, 8'hAD, 4'hE, 8'h00, 0, "gt_71_ad");
        issue(0, 8'h71, 8'hAD, 4'hF, 8'h00, 0, "eq_71_ad");
        issue(0, 8'h71, 8'hAD, 4'h3, 8'h00, 0, "div_71_ad");
        issue(0, 8'hAD, 8'h71, 4'hE, 8'h01, 0, "gt_ad_71");
        issue(0, 8'h80, 8'h81, 4'h1, 8'hFF, 1, "sub_borrow");
        issue(0, 8'h81, 8'h80, 4'h1, 8'h01, 0, "sub_noborrow");

`ifdef ALU_DIV_EN
        issue(0, 8'h35, 8'h00, 4'h3, 8'hFF, 1, "div_by_zero");
        issue(0, 8'hE1, 8'h35, 4'h3, 8'h04, 0, "div_e1_35");
`else
        issue(0, 8'h35, 8'h00, 4'h3, 8'h00, 0, "div_off_zero");
        issue(0, 8'hE1, 8'h35, 4'h3, 8'h00, 0, "div_off_e1_35");
`endif

        // Back-to-back sweep with A=B=0x80
        issue(0, 8'h80, 8'h80, 4'h0, 8'h00, 1, "b2b_add");
        issue(0, 8'h80, 8'h80, 4'h1, 8'h00, 0, "b2b_sub");
        issue(0, 8'h80, 8'h80, 4'h2, 8'h00, 1, "b2b_mul");
`ifdef ALU_DIV_EN
        issue(0, 8'h80, 8'h80, 4'h3, 8'h01, 0, "b2b_div");
`else
        issue(0, 8'h80, 8'h80, 4'h3, 8'h00, 0, "b2b_div");
`endif
        issue(0, 8'h80, 8'h80, 4'h4, 8'h00, 1, "b2b_shl");
        issue(0, 8'h80, 8'h80, 4'h5, 8'h40, 0, "b2b_shr");
        issue(0, 8'h80, 8'h80, 4'h6, 8'h01, 0, "b2b_rol");
        issue(0, 8'h80, 8'h80, 4'h7, 8'h40, 0, "b2b_ror");
        issue(0, 8'h80, 8'h80, 4'h8, 8'h80, 0, "b2b_and");
        issue(0, 8'h80, 8'h80, 4'h9, 8'h80, 0, "b2b_or");
        issue(0, 8'h80, 8'h80, 4'hA, 8'h00, 0, "b2b_xor");
        issue(0, 8'h80, 8'h80, 4'hB, 8'h7F, 0, "b2b_nor");
        issue(0, 8'h80, 8'h80, 4'hC, 8'h7F, 0, "b2b_nand");
        issue(0, 8'h80, 8'h80, 4'hD, 8'hFF, 0, "b2b_xnor");
        issue(0, 8'h80, 8'h80, 4'hE, 8'h00, 0, "b2b_gt");
        issue(0, 8'h80, 8'h80, 4'hF, 8'h01, 0, "b2b_eq");

        // Reset in mid-stream overrides the operation presented that cycle
        issue(0, 8'hFF, 8'h01, 4'h0, 8'h00, 1, "pre_mid_rst");
        issue(1, 8'hFF, 8'h01, 4'h0, 8'h00, 0, "mid_rst");
        issue(0, 8'h0F, 8'hF0, 4'h9, 8'hFF, 0, "post_mid_rst");

        idle();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
